// File: rtl/spi_16b.sv
// ============================================================================
// Module      : spi_16b
// Description : Write-only SPI master (mode 0, active-low CS), 16-bit MSB-first.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_16b #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spi_en,
    input  logic [15:0] spi_data_out,
    output logic        spi_done,
    output logic        SPI_SCK,
    output logic        SPI_CS,
    output logic        SPI_MOSI
);

    // Divider width guarded so CLK_DIV=1 still yields a legal one-bit counter.
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] c_DIV_MAX = DIV_W'(CLK_DIV - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    logic [1:0]       r_state;
    logic [15:0]      r_shift;
    logic [3:0]       r_bit_cnt;
    logic [DIV_W-1:0] r_div;
    logic             r_sck;
    logic             r_cs;
    logic             r_mosi;
    logic             r_done;
    logic             w_phase_end;

    assign w_phase_end = (r_div == c_DIV_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= c_IDLE;
            r_shift   <= 16'd0;
            r_bit_cnt <= 4'd0;
            r_div     <= '0;
            r_sck     <= 1'b0;
            r_cs      <= 1'b1;
            r_mosi    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (spi_en) begin
                        r_shift   <= spi_data_out;
                        r_mosi    <= spi_data_out[15];
                        r_cs      <= 1'b0;
                        r_bit_cnt <= 4'd0;
                        r_div     <= '0;
                        r_state   <= c_SHIFT;
                    end
                end

                c_SHIFT: begin
                    if (w_phase_end) begin
                        r_div <= '0;
                        if (!r_sck) begin
                            r_sck <= 1'b1;
                        end else begin
                            // Falling edge: advance to the next bit or close the frame.
                            r_sck <= 1'b0;
                            if (r_bit_cnt == 4'd15) begin
                                r_cs    <= 1'b1;
                                r_mosi  <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= c_DONE;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                                r_mosi    <= r_shift[14];
                                r_shift   <= {r_shift[14:0], 1'b0};
                            end
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end

                c_DONE: begin
                    if (!spi_en) begin
                        r_done  <= 1'b0;
                        r_state <= c_IDLE;
                    end
                end

                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign spi_done = r_done;
    assign SPI_SCK  = r_sck;
    assign SPI_CS   = r_cs;
    assign SPI_MOSI = r_mosi;

endmodule

`default_nettype wire

// File: tb/tb_spi_16b.sv
// ============================================================================
// Module      : tb_spi_16b
// Description : Scoreboard bench for spi_16b; monitor rebuilds words from SCK.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_16b;

    localparam int CLK_DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spi_en = 1'b0;
    logic [15:0] spi_data_out = 16'd0;
    logic        spi_done;
    logic        SPI_SCK;
    logic        SPI_CS;
    logic        SPI_MOSI;

    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_q[$];

    spi_16b #(.CLK_DIV(CLK_DIV)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .spi_en       (spi_en),
        .spi_data_out (spi_data_out),
        .spi_done     (spi_done),
        .SPI_SCK      (SPI_SCK),
        .SPI_CS       (SPI_CS),
        .SPI_MOSI     (SPI_MOSI)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: rebuilds each frame from MOSI at SCK rises and scores it at CS rise.
    logic        prev_sck  = 1'b0;
    logic        prev_cs   = 1'b1;
    logic        prev_mosi = 1'b0;
    logic [15:0] got       = 16'd0;
    bit          in_frame  = 1'b0;
    int          cs_len    = 0;
    int          hi_len    = 0;
    int          nbits     = 0;
    int          frames    = 0;
    int          mosi_viol = 0;
    logic [15:0] exp_word;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_frame = 1'b0;
        end else begin
            if (prev_cs && !SPI_CS) begin
                if (frames > 0) check("cs_gap_ge2", 32'(hi_len >= 2), 32'd1);
                in_frame = 1'b1;
                cs_len   = 0;
                nbits    = 0;
                got      = 16'd0;
            end
            if (in_frame) begin
                if (!SPI_CS) cs_len++;
                if (SPI_SCK && !prev_sck) begin
                    got = {got[14:0], SPI_MOSI};
                    nbits++;
                end
                if ((SPI_MOSI !== prev_mosi) && SPI_SCK) mosi_viol++;
                if (SPI_CS && !prev_cs) begin
                    in_frame = 1'b0;
                    frames++;
                    hi_len = 0;
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", {16'd0, got}, 32'hFFFF_FFFF);
                    end else begin
                        exp_word = exp_q.pop_front();
                        check("word", {16'd0, got}, {16'd0, exp_word});
                        check("sck_rises", 32'(nbits), 32'd16);
                        check("cs_low_len", 32'(cs_len), 32'(32 * CLK_DIV));
                        check("done_at_cs_rise", {31'd0, spi_done}, 32'd1);
                        check("mosi_idle", {31'd0, SPI_MOSI}, 32'd0);
                    end
                end
            end
            if (SPI_CS) hi_len++;
        end
        prev_sck  = SPI_SCK;
        prev_cs   = SPI_CS;
        prev_mosi = SPI_MOSI;
    end

    task automatic wait_done();
        int n = 0;
        while (!spi_done && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", {31'd0, spi_done}, 32'd1);
    endtask

    task automatic send(input logic [15:0] w);
        spi_data_out = w;
        exp_q.push_back(w);
        spi_en = 1'b1;
    endtask

    initial begin
        int  rises;
        logic psck;

        // Reset held three cycles with spi_en high: request must be ignored.
        rst_n = 1'b0;
        spi_en = 1'b1;
        spi_data_out = 16'hFFFF;
        repeat (3) @(negedge clk);
        check("rst_sck",  {31'd0, SPI_SCK},  32'd0);
        check("rst_cs",   {31'd0, SPI_CS},   32'd1);
        check("rst_mosi", {31'd0, SPI_MOSI}, 32'd0);
        check("rst_done", {31'd0, spi_done}, 32'd0);
        spi_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_cs", {31'd0, SPI_CS}, 32'd1);

        // Single word
        send(16'hAA00);
        wait_done();

        // Hold request high: done held, no repeat transfer
        repeat (20) @(negedge clk);
        check("hold_done", {31'd0, spi_done}, 32'd1);
        check("hold_cs",   {31'd0, SPI_CS},   32'd1);
        spi_en = 1'b0;
        @(negedge clk);
        check("release_done", {31'd0, spi_done}, 32'd0);

        // Second word after 100ns
        spi_data_out = 16'h0055;
        #100;
        send(16'h0055);
        wait_done();
        spi_en = 1'b0;
        @(negedge clk);

        // Data and request changes mid-transfer are ignored
        send(16'h3C5A);
        @(negedge clk);
        spi_en = 1'b0;
        repeat (40) @(negedge clk);
        spi_data_out = 16'hFFFF;
        wait_done();

        // Earliest back-to-back restart
        @(negedge clk);
        send(16'h8001);
        wait_done();
        spi_en = 1'b0;
        @(negedge clk);

        // Abort after the 5th SCK rise
        spi_data_out = 16'hF0F0;
        spi_en = 1'b1;
        rises = 0;
        psck  = SPI_SCK;
        for (int n = 0; n < 1000 && rises < 5; n++) begin
            @(negedge clk);
            if (SPI_SCK && !psck) rises++;
            psck = SPI_SCK;
        end
        check("abort_rises_seen", 32'(rises), 32'd5);
        rst_n = 1'b0;
        spi_en = 1'b0;
        @(negedge clk);
        check("abort_cs",   {31'd0, SPI_CS},   32'd1);
        check("abort_sck",  {31'd0, SPI_SCK},  32'd0);
        check("abort_done", {31'd0, spi_done}, 32'd0);
        check("abort_mosi", {31'd0, SPI_MOSI}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Fresh transfer after abort
        send(16'h1234);
        wait_done();
        spi_en = 1'b0;
        repeat (5) @(negedge clk);

        check("frames_done",  32'(frames), 32'd5);
        check("queue_empty",  32'(exp_q.size()), 32'd0);
        check("mosi_only_sck_low", 32'(mosi_viol), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
